// File: rtl/cmp_pipe_stage.sv
// -----------------------------------------------------------------------------
// cmp_pipe_stage
//
// Two-stage elastic pipeline around an 8-bit combinational comparator.
// Stage 1 registers the operand pair and compare function. The comparator
// evaluates the stage-1 registers. Stage 2 registers the 1-bit result and the
// function that produced it. The stage runs at full throughput while the
// consumer is ready, and holds two transactions when the consumer stalls.
//
// Optional feature (macro CMP_HIT_COUNT_EN):
//   When the macro is defined, a saturating counter tallies consumed true
//   results, and hit_clr clears it synchronously. When the macro is undefined,
//   no counter is built, hit_count reads 0 and hit_clr is ignored. The port
//   list is the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  stage can accept an operand pair this cycle
//   in_a       in   operand A [7:0]
//   in_b       in   operand B [7:0]
//   in_func    in   [2]=signed, [1:0]=00 EQ / 01 GT / 10 LT / 11 NE
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   out_result out  compare result
//   out_func   out  function that produced out_result
//   hit_clr    in   synchronous clear of hit_count
//   hit_count  out  [CNT_W-1:0] consumed true results, saturating
// -----------------------------------------------------------------------------

// Combinational 8-bit comparator.
// op: 00 EQ, 01 GT, 10 LT, 11 reserved (always 0).
// isSigned selects a two's-complement ordering for GT and LT.
module comparator_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    input  logic       isSigned,
    output logic       result
);
    logic isEq;
    logic isGt;

    always_comb begin
        isEq = (a == b);
        if (isSigned) begin
            isGt = ($signed(a) > $signed(b));
        end else begin
            isGt = (a > b);
        end
        case (op)
            2'b00:   result = isEq;
            2'b01:   result = isGt;
            2'b10:   result = !isGt && !isEq;
            default: result = 1'b0;
        endcase
    end
endmodule

module cmp_pipe_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [2:0]       in_func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [2:0]       out_func,
    input  logic             hit_clr,
    output logic [CNT_W-1:0] hit_count
);
    // Stage 1: registered operands
    logic       s1_valid;
    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic [2:0] s1_func;

    // Stage 2: registered result
    logic       s2_valid;
    logic       s2_result;
    logic [2:0] s2_func;

    logic s2_adv;
    logic s1_adv;
    logic inAccept;
    logic s1Load;

    logic [1:0] cmpOp;
    logic       cmpRaw;
    logic       cmpResult;

    // Handshake. in_ready depends combinationally on out_ready. This lets a
    // full pipe accept new input in the same cycle it hands a result off.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid || s1_adv;
    assign inAccept = in_valid && in_ready;
    assign s1Load   = s1_valid && s2_adv;

    // NE reuses the EQ compare and inverts the result.
    assign cmpOp     = (s1_func[1:0] == 2'b11) ? 2'b00 : s1_func[1:0];
    assign cmpResult = cmpRaw ^ (s1_func[1:0] == 2'b11);

    comparator_8bit uComparator (
        .a        (s1_a),
        .b        (s1_b),
        .op       (cmpOp),
        .isSigned (s1_func[2]),
        .result   (cmpRaw)
    );

    // Stage 1. The valid bit follows in_valid whenever the stage can take
    // input. The data registers load only on an accepted transfer, so they
    // never pick up X from idle inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= 8'h00;
            s1_b     <= 8'h00;
            s1_func  <= 3'b000;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (inAccept) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_func <= in_func;
            end
        end
    end

    // Stage 2. The result and function registers hold while stalled, so the
    // outputs stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= 1'b0;
            s2_func   <= 3'b000;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1Load) begin
                s2_result <= cmpResult;
                s2_func   <= s1_func;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_func   = s2_func;

`ifdef CMP_HIT_COUNT_EN
    logic [CNT_W-1:0] hitCountReg;
    logic             hitInc;

    assign hitInc = s2_valid && out_ready && s2_result;

    // A clear overrides an increment in the same cycle.
    // At all-ones the counter holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCountReg <= '0;
        end else if (hit_clr) begin
            hitCountReg <= '0;
        end else if (hitInc && !(&hitCountReg)) begin
            hitCountReg <= hitCountReg + 1'b1;
        end
    end

    assign hit_count = hitCountReg;
`else
    // hit_clr has no effect in this build.
    logic unusedHitClr;
    assign unusedHitClr = hit_clr;
    assign hit_count    = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_stage.sv
module tb_cmp_pipe_stage;
    localparam int CNT_W = 2;
`ifdef CMP_HIT_COUNT_EN
    localparam int HIT_EN = 1;
`else
    localparam int HIT_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = 8'h00;
    logic [7:0]       in_b = 8'h00;
    logic [2:0]       in_func = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_result;
    logic [2:0]       out_func;
    logic             hit_clr = 1'b0;
    logic [CNT_W-1:0] hit_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] sb[$];   // {expected result, func}
    int accCyc[$];
    int outCyc[$];

    cmp_pipe_stage #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_func    (in_func),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_func   (out_func),
        .hit_clr    (hit_clr),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic refCmp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        int va;
        int vb;
        va = f[2] ? int'($signed(a)) : int'(a);
        vb = f[2] ? int'($signed(b)) : int'(b);
        case (f[1:0])
            2'b00:   return va == vb;
            2'b01:   return va > vb;
            2'b10:   return va < vb;
            default: return va != vb;
        endcase
    endfunction

    // Monitor: a transfer happens on the posedge that follows this negedge.
    always @(negedge clk) begin
        logic [3:0] e;
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", {31'b0, out_result}, {31'b0, e[3]});
                check("func", {29'b0, out_func}, {29'b0, e[2:0]});
                $display("out: result=%0d func=%03b", out_result, out_func);
                outCyc.push_back(cyc);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back({refCmp(in_a, in_b, in_func), in_func});
            accCyc.push_back(cyc);
            $display("in : a=%02h b=%02h func=%03b", in_a, in_b, in_func);
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        bit ok = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_func = f;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset state
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", {31'b0, out_result}, 32'd0);
        check("rst_out_func", {29'b0, out_func}, 32'd0);
        check("rst_hit_count", {30'b0, hit_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Signedness, NE and EQ
        send(8'h80, 8'h01, 3'b001);
        send(8'h80, 8'h01, 3'b101);
        send(8'h80, 8'h01, 3'b110);
        send(8'h05, 8'h05, 3'b011);
        send(8'h05, 8'h05, 3'b000);
        send(8'h05, 8'h06, 3'b011);
        drain();

        // Throughput: 8 back-to-back
        accCyc.delete();
        outCyc.delete();
        for (int i = 0; i < 8; i++) send(8'(i), 8'h03, 3'b001);
        drain();
        check("tp_count", outCyc.size(), 32'd8);
        if (outCyc.size() == 8 && accCyc.size() == 8) begin
            check("tp_latency", outCyc[0] - accCyc[0], 32'd2);
            for (int i = 1; i < 8; i++) check("tp_bubble", outCyc[i] - outCyc[0], i);
        end

        // Backpressure
        out_ready = 1'b0;
        send(8'h80, 8'h01, 3'b001);
        send(8'h80, 8'h01, 3'b101);
        in_valid = 1'b1;
        in_a = 8'h80;
        in_b = 8'h01;
        in_func = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_hold_result", {31'b0, out_result}, 32'd1);
            check("bp_hold_func", {29'b0, out_func}, 32'd1);
        end
        tick();
        out_ready = 1'b1;
        send(8'h80, 8'h01, 3'b110);
        drain();

        // Counter saturation
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h05, 8'h05, 3'b000);
        drain();
        tick();
        check("hit_sat", {30'b0, hit_count}, HIT_EN ? 32'd3 : 32'd0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(8'h05, 8'h05, 3'b000);
        send(8'h05, 8'h06, 3'b011);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_out_result", {31'b0, out_result}, 32'd0);
        check("arst_out_func", {29'b0, out_func}, 32'd0);
        check("arst_hit_count", {30'b0, hit_count}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end
        tick();

        // Clear wins over a simultaneous increment
        send(8'h05, 8'h05, 3'b000);
        drain();
        tick();
        check("hit_one", {30'b0, hit_count}, HIT_EN ? 32'd1 : 32'd0);
        out_ready = 1'b0;
        send(8'h07, 8'h07, 3'b000);
        tick();
        check("clr_staged", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        check("hit_clr_wins", {30'b0, hit_count}, 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 32'd1, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cmp_pipe_stage.md
# cmp_pipe_stage

Two-stage elastic pipeline wrapped around the 8-bit comparator datapath. Accepts operand pairs and a 3-bit compare function over a valid/ready handshake, drives the combinational `comparator_8bit` from registered operands, and registers the 1-bit result for the downstream consumer at full throughput. An optional saturating hit counter tallies consumed true results for the status block.

## Interface

Parameters:

- `CNT_W`, default 16: width of the hit counter.

Ports:

- `clk`: in, 1. Single clock, rising edge.
- `rst_n`: in, 1. Reset, asynchronous and active-low.
- `in_valid`: in, 1. Operand pair valid.
- `in_ready`: out, 1. Stage can accept an operand pair this cycle.
- `in_a`: in, 8. Operand A.
- `in_b`: in, 8. Operand B.
- `in_func`: in, 3. Compare function; encoding under Operation.
- `out_valid`: out, 1. Result valid.
- `out_ready`: in, 1. Consumer accepts the result.
- `out_result`: out, 1. Compare result.
- `out_func`: out, 3. Function that produced `out_result`.
- `hit_clr`: in, 1. Synchronous clear of `hit_count`.
- `hit_count`: out, `CNT_W`. Consumed true results, saturating.

## Operation

- `in_func[2]` is S: 1 means signed two's-complement, 0 means unsigned.
- `in_func[1:0]` selects the compare:
  - 00: EQ.
  - 01: GT.
  - 10: LT.
  - 11: NE. The stage drives op=00 to the comparator and inverts its result.
- S has no effect on EQ or NE.
- Stage 1 holds `s1_valid`, `s1_a`, `s1_b` and `s1_func`. The comparator is instantiated combinationally on the stage-1 registers.
- Stage 2 holds `s2_valid`, the result (shown on `out_result`) and `s2_func` (shown on `out_func`).
- Advance rules:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = s2_adv`. Stage 1 loads stage 2 when `s1_valid & s2_adv`.
  - `in_ready = !s1_valid | s2_adv`. This is combinational from `out_ready` and intended.
- Handshake:
  - A transfer occurs on a cycle where valid & ready are both 1.
  - The stage never drops or reorders transactions.
  - `out_result` and `out_func` are held stable while `out_valid=1` and `out_ready=0`.
  - Inputs are don't-care when `in_valid=0`.
- Outputs for an invalid slot are don't-care. The RTL must not generate X: registers load only on enable.
- Hit counter:
  - Increments by 1 on a cycle with `out_valid & out_ready & out_result`.
  - Saturates at all-ones and holds there.
  - `hit_clr` forces it to 0 on the next edge and wins over a simultaneous increment.

## Timing

- Reset values: `in_ready`=1; `out_valid`=0; `out_result`=0; `out_func`=3'b000; `hit_count`=0. Both internal valids are 0.
- Latency is 2 cycles. An operand accepted at edge N shows `out_valid=1` after edge N+1, so it is consumable at edge N+2.
- Throughput is 1 transaction per cycle while `out_ready=1`.
- With `out_ready=0` the stage holds 2 transactions, then `in_ready` drops.
- Reset asserted mid-operation:
  - All in-flight transactions are discarded immediately (asynchronous).
  - Outputs return to their reset values; no partial result is emitted.
- After release, the first accept is allowed on the first rising edge with `rst_n=1`.

## Configuration

- Macro: `CMP_HIT_COUNT_EN`.
- Defined: the hit counter behaves as described under Operation.
- Undefined:
  - No counter register is built.
  - `hit_count` is tied to 0 and `hit_clr` is ignored.
  - The port list is unchanged.

## Test plan

- Signedness: A=8'h80, B=8'h01.
  - func=3'b001 (unsigned GT) gives result 1.
  - func=3'b101 (signed GT) gives result 0.
  - func=3'b110 (signed LT) gives result 1.
- NE and EQ:
  - A=8'h05, B=8'h05: func=3'b011 gives 0; func=3'b000 gives 1.
  - A=8'h05, B=8'h06: func=3'b011 gives 1.
  - `out_func` echoes the input function in every case.
- Throughput: `out_ready`=1, 8 back-to-back accepts of A=i, B=3, func=3'b001.
  - The first `out_valid` appears 2 edges after the first accept.
  - Results are 0,0,0,0,1,1,1,1 on consecutive cycles with no bubbles.
- Backpressure: `out_ready`=0 while pushing 3 transactions.
  - The first 2 are accepted; `in_ready`=0 on the 3rd.
  - `out_result` and `out_func` stay stable.
  - After `out_ready`=1, all 3 emerge in order.
- Counter with CNT_W=2 and `CMP_HIT_COUNT_EN` defined:
  - 5 true results consumed gives `hit_count`=3 (saturated).
  - A true-result consume in the same cycle as `hit_clr` gives 0.
  - With the macro undefined, `hit_count` stays 0.
- Reset: assert `rst_n`=0 with both stages full and `out_ready`=0.
  - `out_valid`, `out_result`, `out_func` and `hit_count` go to 0 and `in_ready` to 1 without waiting for a clock edge.
  - No stale result appears after release.
